// File: rtl/csr_commit_ctrl_pkg.sv
// Shared types and helpers for the CSR commit sequencer.
// Holds the op and state encodings and the list of CSRs that force a pipeline flush.
package csr_commit_ctrl_pkg;

    typedef enum logic [1:0] {
        CsrRead = 2'd0,
        CsrRw   = 2'd1,
        CsrSet  = 2'd2,
        CsrClr  = 2'd3
    } csr_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StPending,
        StAccess,
        StFlush,
        StExc
    } csr_ctrl_state_e;

    localparam logic [11:0] CsrSstatus = 12'h100;
    localparam logic [11:0] CsrSie     = 12'h104;
    localparam logic [11:0] CsrSatp    = 12'h180;
    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMie     = 12'h304;

    // Writes to these CSRs change translation or interrupt state seen by younger instructions.
    function automatic logic is_side_effect_csr(logic [11:0] addr);
        return (addr == CsrSstatus) || (addr == CsrSie) || (addr == CsrSatp) ||
               (addr == CsrMstatus) || (addr == CsrMie);
    endfunction

endpackage

// File: rtl/csr_commit_ctrl.sv
// Sequencer for the single-entry CSR buffer: capture at issue, wait for ROB-head commit,
// drive the CSR file access, then flush or raise an exception as needed.
module csr_commit_ctrl
    import csr_commit_ctrl_pkg::*;
#(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     csr_valid_i,
    input  logic [TRANS_ID_BITS-1:0] csr_trans_id_i,
    input  logic [1:0]               csr_op_i,
    input  logic [11:0]              csr_addr_i,
    input  logic [XLEN-1:0]          csr_wdata_i,
    output logic                     busy_o,
    input  logic                     commit_valid_i,
    input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
    output logic                     commit_ack_o,
    output logic                     buf_commit_o,
    output logic                     csr_req_o,
    output logic [1:0]               csr_op_o,
    output logic [11:0]              csr_addr_o,
    output logic [XLEN-1:0]          csr_wdata_o,
    input  logic                     csr_done_i,
    input  logic                     csr_exception_i,
    output logic                     flush_req_o,
    output logic                     exception_o,
    output logic [TRANS_ID_BITS-1:0] exc_trans_id_o
);

    csr_ctrl_state_e          state_q, state_d;
    logic [TRANS_ID_BITS-1:0] id_q;
    csr_op_e                  op_q;
    logic [11:0]              addr_q;
    logic [XLEN-1:0]          wdata_q;

    logic capture;
    logic id_match;

    assign capture  = (state_q == StIdle) && csr_valid_i && !flush_i;
    assign id_match = commit_valid_i && (commit_trans_id_i == id_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q    <= '0;
            op_q    <= CsrRead;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            id_q    <= csr_trans_id_i;
            op_q    <= csr_op_e'(csr_op_i);
            addr_q  <= csr_addr_i;
            wdata_q <= csr_wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (capture) state_d = StPending;
            end
            StPending: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (id_match) begin
                    state_d = StAccess;
                end
            end
            // Op is architecturally committed here, so a speculative flush cannot cancel it.
            StAccess: begin
                if (csr_done_i) begin
                    if (csr_exception_i) begin
                        state_d = StExc;
                    end else if (is_side_effect_csr(addr_q) && (op_q != CsrRead)) begin
                        state_d = StFlush;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StFlush: state_d = StIdle;
            StExc:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o         = (state_q != StIdle);
        commit_ack_o   = 1'b0;
        buf_commit_o   = 1'b0;
        csr_req_o      = 1'b0;
        csr_op_o       = '0;
        csr_addr_o     = '0;
        csr_wdata_o    = '0;
        flush_req_o    = 1'b0;
        exception_o    = 1'b0;
        exc_trans_id_o = '0;
        unique case (state_q)
            StPending: begin
                commit_ack_o = id_match && !flush_i;
                buf_commit_o = id_match && !flush_i;
            end
            StAccess: begin
                csr_req_o   = 1'b1;
                csr_op_o    = op_q;
                csr_addr_o  = addr_q;
                csr_wdata_o = wdata_q;
            end
            StFlush: flush_req_o = 1'b1;
            StExc: begin
                exception_o    = 1'b1;
                exc_trans_id_o = id_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Self-checking bench for csr_commit_ctrl: per-cycle stimulus rows with expected outputs
// queued alongside, popped and compared once the DUT has settled in that cycle.
module tb_csr_commit_ctrl;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TIDB = 3;

    logic            clk = 1'b0;
    logic            rst_i, flush_i, csr_valid_i, commit_valid_i, csr_done_i, csr_exception_i;
    logic [TIDB-1:0] csr_trans_id_i, commit_trans_id_i;
    logic [1:0]      csr_op_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic            busy_o, commit_ack_o, buf_commit_o, csr_req_o, flush_req_o, exception_o;
    logic [1:0]      csr_op_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic [TIDB-1:0] exc_trans_id_o;

    always #5 clk = ~clk;

    csr_commit_ctrl #(.XLEN(XLEN), .TRANS_ID_BITS(TIDB)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .csr_valid_i       (csr_valid_i),
        .csr_trans_id_i    (csr_trans_id_i),
        .csr_op_i          (csr_op_i),
        .csr_addr_i        (csr_addr_i),
        .csr_wdata_i       (csr_wdata_i),
        .busy_o            (busy_o),
        .commit_valid_i    (commit_valid_i),
        .commit_trans_id_i (commit_trans_id_i),
        .commit_ack_o      (commit_ack_o),
        .buf_commit_o      (buf_commit_o),
        .csr_req_o         (csr_req_o),
        .csr_op_o          (csr_op_o),
        .csr_addr_o        (csr_addr_o),
        .csr_wdata_o       (csr_wdata_o),
        .csr_done_i        (csr_done_i),
        .csr_exception_i   (csr_exception_i),
        .flush_req_o       (flush_req_o),
        .exception_o       (exception_o),
        .exc_trans_id_o    (exc_trans_id_o)
    );

    typedef struct packed {
        logic            rst;
        logic            flush;
        logic            valid;
        logic [TIDB-1:0] tid;
        logic [1:0]      op;
        logic [11:0]     addr;
        logic [XLEN-1:0] wdata;
        logic            cv;
        logic [TIDB-1:0] ctid;
        logic            done;
        logic            exc;
    } stim_t;

    // {busy, ack, buf_commit, req, op, addr, wdata, flush_req, exception, exc_id}
    typedef logic [86:0] ovec_t;

    stim_t stim_q[$];
    ovec_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    function automatic stim_t s_idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t s_issue(logic [TIDB-1:0] id, logic [1:0] op, logic [11:0] addr,
                                      logic [XLEN-1:0] wd);
        stim_t s = '0;
        s.valid = 1'b1; s.tid = id; s.op = op; s.addr = addr; s.wdata = wd;
        return s;
    endfunction

    function automatic stim_t s_commit(logic [TIDB-1:0] id);
        stim_t s = '0;
        s.cv = 1'b1; s.ctid = id;
        return s;
    endfunction

    function automatic stim_t s_done(logic exc);
        stim_t s = '0;
        s.done = 1'b1; s.exc = exc;
        return s;
    endfunction

    function automatic ovec_t e_idle();
        return '0;
    endfunction

    function automatic ovec_t e_busy();
        return {1'b1, 86'd0};
    endfunction

    function automatic ovec_t e_ack();
        return {3'b111, 84'd0};
    endfunction

    function automatic ovec_t e_req(logic [1:0] op, logic [11:0] addr, logic [XLEN-1:0] wd);
        return {3'b100, 1'b1, op, addr, wd, 2'b00, 3'd0};
    endfunction

    function automatic ovec_t e_flush();
        return {1'b1, 81'd0, 2'b10, 3'd0};
    endfunction

    function automatic ovec_t e_exc(logic [TIDB-1:0] id);
        return {1'b1, 81'd0, 2'b01, id};
    endfunction

    function automatic ovec_t observed();
        return {busy_o, commit_ack_o, buf_commit_o, csr_req_o, csr_op_o, csr_addr_o, csr_wdata_o,
                flush_req_o, exception_o, exc_trans_id_o};
    endfunction

    task automatic add(input stim_t s, input ovec_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        rst_i = s.rst; flush_i = s.flush; csr_valid_i = s.valid; csr_trans_id_i = s.tid;
        csr_op_i = s.op; csr_addr_i = s.addr; csr_wdata_i = s.wdata; commit_valid_i = s.cv;
        commit_trans_id_i = s.ctid; csr_done_i = s.done; csr_exception_i = s.exc;
    endtask

    task automatic test_reset();
        stim_t s;
        ovec_t e, o;
        int cyc = 0;
        s = s_issue(3'd7, 2'd1, 12'h300, 64'hFFFF); s.rst = 1'b1;
        add(s, e_idle());
        add(s, e_idle());
        add(s_idle(), e_idle());
        add(s_commit(3'd7), e_idle());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); apply(s); #1;
            o = observed(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL reset c%0d got %h want %h", cyc, o, e);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_basic_rw();
        stim_t s;
        ovec_t e, o;
        int cyc = 0;
        add(s_issue(3'd2, 2'd1, 12'h340, 64'hDEAD_BEEF_0123_4567), e_idle());
        add(s_commit(3'd2), e_ack());
        add(s_done(1'b0), e_req(2'd1, 12'h340, 64'hDEAD_BEEF_0123_4567));
        add(s_idle(), e_idle());
        add(s_idle(), e_idle());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); apply(s); #1;
            o = observed(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL basic_rw c%0d got %h want %h", cyc, o, e);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_side_effect();
        stim_t s;
        ovec_t e, o;
        int cyc = 0;
        add(s_issue(3'd5, 2'd2, 12'h180, 64'h8), e_idle());
        add(s_commit(3'd5), e_ack());
        add(s_done(1'b0), e_req(2'd2, 12'h180, 64'h8));
        add(s_idle(), e_flush());
        add(s_idle(), e_idle());
        // READ of a side-effect CSR must not flush
        add(s_issue(3'd1, 2'd0, 12'h300, 64'h0), e_idle());
        add(s_commit(3'd1), e_ack());
        add(s_done(1'b0), e_req(2'd0, 12'h300, 64'h0));
        add(s_idle(), e_idle());
        // CLR to mie does flush
        add(s_issue(3'd0, 2'd3, 12'h304, 64'hA0), e_idle());
        add(s_commit(3'd0), e_ack());
        add(s_done(1'b0), e_req(2'd3, 12'h304, 64'hA0));
        add(s_idle(), e_flush());
        add(s_idle(), e_idle());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); apply(s); #1;
            o = observed(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL side_effect c%0d got %h want %h", cyc, o, e);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_id_match();
        stim_t s;
        ovec_t e, o;
        int cyc = 0;
        add(s_issue(3'd3, 2'd1, 12'h341, 64'h55), e_idle());
        s = s_commit(3'd1);
        s.valid = 1'b1; s.tid = 3'd1; s.addr = 12'h100; s.wdata = 64'h99;
        add(s, e_busy());
        add(s_commit(3'd3), e_ack());
        s = s_idle(); s.exc = 1'b1;
        add(s, e_req(2'd1, 12'h341, 64'h55));
        add(s_done(1'b0), e_req(2'd1, 12'h341, 64'h55));
        add(s_idle(), e_idle());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); apply(s); #1;
            o = observed(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL id_match c%0d got %h want %h", cyc, o, e);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_flush();
        stim_t s;
        ovec_t e, o;
        int cyc = 0;
        add(s_issue(3'd4, 2'd3, 12'h304, 64'h1), e_idle());
        add(s_idle(), e_busy());
        s = s_commit(3'd4); s.flush = 1'b1;
        add(s, e_busy());
        add(s_commit(3'd4), e_idle());
        s = s_issue(3'd4, 2'd1, 12'h340, 64'h2); s.flush = 1'b1;
        add(s, e_idle());
        add(s_commit(3'd4), e_idle());
        add(s_issue(3'd4, 2'd1, 12'h340, 64'h3), e_idle());
        add(s_commit(3'd4), e_ack());
        s = s_idle(); s.flush = 1'b1;
        add(s, e_req(2'd1, 12'h340, 64'h3));
        s = s_done(1'b0); s.flush = 1'b1;
        add(s, e_req(2'd1, 12'h340, 64'h3));
        add(s_idle(), e_idle());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); apply(s); #1;
            o = observed(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL flush c%0d got %h want %h", cyc, o, e);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_exception_and_reset();
        stim_t s;
        ovec_t e, o;
        int cyc = 0;
        // Exception wins over the side-effect flush on mstatus
        add(s_issue(3'd6, 2'd1, 12'h300, 64'h77), e_idle());
        add(s_commit(3'd6), e_ack());
        add(s_done(1'b1), e_req(2'd1, 12'h300, 64'h77));
        add(s_idle(), e_exc(3'd6));
        add(s_idle(), e_idle());
        add(s_issue(3'd7, 2'd2, 12'h305, 64'hF0), e_idle());
        add(s_commit(3'd7), e_ack());
        add(s_idle(), e_req(2'd2, 12'h305, 64'hF0));
        s = s_done(1'b1); s.rst = 1'b1;
        add(s, e_req(2'd2, 12'h305, 64'hF0));
        add(s_idle(), e_idle());
        add(s_commit(3'd7), e_idle());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); apply(s); #1;
            o = observed(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL exc_reset c%0d got %h want %h", cyc, o, e);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        ovec_t e, o;
        int cyc = 0;
        add(s_issue(3'd1, 2'd1, 12'h340, 64'h11), e_idle());
        add(s_commit(3'd1), e_ack());
        add(s_done(1'b0), e_req(2'd1, 12'h340, 64'h11));
        add(s_issue(3'd2, 2'd2, 12'h341, 64'h22), e_idle());
        add(s_commit(3'd2), e_ack());
        add(s_done(1'b0), e_req(2'd2, 12'h341, 64'h22));
        add(s_idle(), e_idle());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); apply(s); #1;
            o = observed(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) $display("FAIL back_to_back c%0d got %h want %h", cyc, o, e);
            else n_pass++;
            cyc++;
        end
    endtask

    initial begin
        apply(s_idle());
        rst_i = 1'b1;
        test_reset();
        test_basic_rw();
        test_side_effect();
        test_id_match();
        test_flush();
        test_exception_and_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
